// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hazard / exception controller.
//   Arbitrates per-stage stall requests and sequences the exception flush.
//   It waits one IDLE detection cycle, then one FLUSH cycle that pulses
//   flush, then two REFILL cycles.
//   It also watches for stall requests that are held for too long.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   stallreq_id/ex/mem  stall requests from decode / execute / memory
//   excepttype_i        exception code from memory stage (0 = none)
//   epc_i               return address used for eret (code 0xe)
//   stall[5:0]          per-stage hold: pc, if, id, ex, mem, wb
//   flush               one-cycle registered flush pulse
//   new_pc              redirect target, meaningful while flush=1
//   busy                high outside IDLE
//   stall_timeout       sticky: some stall request held for 255 cycles
module pipe_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        busy,
  output logic        stall_timeout
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FLUSH  = 2'd1;
  localparam logic [1:0] ST_REFILL = 2'd2;

  logic [1:0]  r_state, w_state_d;
  logic        r_refill_cnt, w_refill_cnt_d;
  logic [31:0] r_new_pc, w_new_pc_d;
  logic [7:0]  r_cnt, w_cnt_d;
  logic        r_timeout;

  logic        w_exc_take;
  logic        w_any_req;
  logic [5:0]  w_stall_req;
  logic [31:0] w_target;

  // Exceptions are only accepted in IDLE; REFILL deliberately ignores them.
  assign w_exc_take = (r_state == ST_IDLE) && (excepttype_i != 32'h0);
  assign w_any_req  = stallreq_id | stallreq_ex | stallreq_mem;

  always_comb begin
    w_stall_req = 6'b000000;
    if (stallreq_mem)     w_stall_req = 6'b011111;
    else if (stallreq_ex) w_stall_req = 6'b001111;
    else if (stallreq_id) w_stall_req = 6'b000111;
  end

  always_comb begin
    w_target = 32'h00000040;
    if (excepttype_i == 32'h00000001)      w_target = 32'h00000020;
    else if (excepttype_i == 32'h0000000e) w_target = epc_i;
  end

  // The stall output is combinational, so reset has to gate it explicitly.
  always_comb begin
    stall = w_stall_req;
    if (rst || (r_state == ST_FLUSH) || w_exc_take) stall = 6'b000000;
  end

  always_comb begin
    w_state_d      = r_state;
    w_refill_cnt_d = r_refill_cnt;
    w_new_pc_d     = r_new_pc;
    case (r_state)
      ST_IDLE: begin
        if (w_exc_take) begin
          w_state_d  = ST_FLUSH;
          w_new_pc_d = w_target;
        end
      end
      ST_FLUSH: begin
        w_state_d      = ST_REFILL;
        w_refill_cnt_d = 1'b0;
      end
      ST_REFILL: begin
        if (r_refill_cnt) w_state_d = ST_IDLE;
        w_refill_cnt_d = 1'b1;
      end
      default: w_state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    w_cnt_d = r_cnt;
    if ((r_state == ST_FLUSH) || !w_any_req) w_cnt_d = 8'h00;
    else if (r_cnt != 8'hff)                 w_cnt_d = r_cnt + 8'h01;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_refill_cnt <= 1'b0;
      r_new_pc     <= 32'h00000000;
      r_cnt        <= 8'h00;
      r_timeout    <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_refill_cnt <= w_refill_cnt_d;
      r_new_pc     <= w_new_pc_d;
      r_cnt        <= w_cnt_d;
      r_timeout    <= r_timeout | (w_cnt_d == 8'hff);
    end
  end

  assign flush         = (r_state == ST_FLUSH);
  assign busy          = (r_state != ST_IDLE);
  assign new_pc        = r_new_pc;
  assign stall_timeout = r_timeout;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl. The driver pushes the expected outputs of
// each cycle from a countdown/arithmetic reference model. A negedge monitor
// pops each entry and compares it with the DUT.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stallreq_id = 1'b0, stallreq_ex = 1'b0, stallreq_mem = 1'b0;
  logic [31:0] excepttype_i = 32'h0, epc_i = 32'h0;
  logic [5:0]  stall;
  logic        flush, busy, stall_timeout;
  logic [31:0] new_pc;

  pipe_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .stallreq_mem (stallreq_mem),
    .excepttype_i (excepttype_i),
    .epc_i        (epc_i),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .busy         (busy),
    .stall_timeout(stall_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        busy;
    logic        timeout;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: cycles of busy remaining after an accepted exception.
  int          m_busy_left = 0;
  logic [31:0] m_new_pc    = 32'h0;
  int          m_cnt       = 0;
  logic        m_timeout   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("stall",   {26'h0, stall},          {26'h0, e.stall});
      check("flush",   {31'h0, flush},          {31'h0, e.flush});
      check("new_pc",  new_pc,                  e.new_pc);
      check("busy",    {31'h0, busy},           {31'h0, e.busy});
      check("timeout", {31'h0, stall_timeout},  {31'h0, e.timeout});
    end
  end

  function automatic logic [5:0] prio(input logic id, input logic ex, input logic mem);
    if (mem) return 6'b011111;
    if (ex)  return 6'b001111;
    if (id)  return 6'b000111;
    return 6'b000000;
  endfunction

  function automatic logic [31:0] target(input logic [31:0] code, input logic [31:0] epc);
    if (code == 32'h1) return 32'h20;
    if (code == 32'he) return epc;
    return 32'h40;
  endfunction

  task automatic model_reset();
    m_busy_left = 0;
    m_new_pc    = 32'h0;
    m_cnt       = 0;
    m_timeout   = 1'b0;
  endtask

  // Applies one cycle of inputs, records expected outputs, advances the model.
  task automatic drive(input logic id, input logic ex, input logic mem,
                       input logic [31:0] exc, input logic [31:0] epc);
    exp_t e;
    bit   in_flush, take, any;
    @(posedge clk);
    #1;
    stallreq_id = id; stallreq_ex = ex; stallreq_mem = mem;
    excepttype_i = exc; epc_i = epc;
    in_flush  = (m_busy_left == 3);
    take      = (m_busy_left == 0) && (exc != 0);
    any       = id | ex | mem;
    e.stall   = (in_flush || take) ? 6'b0 : prio(id, ex, mem);
    e.flush   = in_flush;
    e.new_pc  = m_new_pc;
    e.busy    = (m_busy_left > 0);
    e.timeout = m_timeout;
    q.push_back(e);
    if (in_flush || !any) m_cnt = 0;
    else if (m_cnt < 255) m_cnt = m_cnt + 1;
    if (m_cnt == 255) m_timeout = 1'b1;
    if (take) begin
      m_new_pc    = target(exc, epc);
      m_busy_left = 3;
    end else if (m_busy_left > 0) begin
      m_busy_left = m_busy_left - 1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    stallreq_id = 1'b1; stallreq_ex = 1'b1; stallreq_mem = 1'b1;
    excepttype_i = 32'h1;
    #1;
    check("rst_stall",   {26'h0, stall}, 32'h0);
    check("rst_flush",   {31'h0, flush}, 32'h0);
    check("rst_busy",    {31'h0, busy},  32'h0);
    check("rst_new_pc",  new_pc,         32'h0);
    check("rst_timeout", {31'h0, stall_timeout}, 32'h0);
    @(posedge clk);
    #1;
    check("rst_stall_edge", {26'h0, stall}, 32'h0);
    check("rst_busy_edge",  {31'h0, busy},  32'h0);
    rst = 1'b0;
    stallreq_id = 1'b0; stallreq_ex = 1'b0; stallreq_mem = 1'b0;
    excepttype_i = 32'h0;
    model_reset();
  endtask

  initial begin
    logic [31:0] codes [4];
    codes[0] = 32'h1; codes[1] = 32'he; codes[2] = 32'hc; codes[3] = 32'h0;

    do_reset();

    // Stall priority.
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 1, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);

    // Interrupt for one cycle, then idle long enough to see busy drop.
    drive(0, 0, 0, 32'h1, 0);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0);

    // Eret while memory stalls in the same cycle.
    drive(0, 0, 1, 32'he, 32'h1234);
    for (int i = 0; i < 4; i++) drive(0, 1, 0, 0, 0);

    // Exception held for 4 cycles, then held long enough for a second flush.
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 32'hc, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) drive(1, 0, 0, 32'h7, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] c;
      c = 32'h0;
      if ($urandom_range(0, 7) == 0) begin
        codes[3] = $urandom();
        c = codes[$urandom_range(0, 3)];
      end
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0, c, $urandom());
    end

    // Long execute stall: timeout appears at count 255 and stays sticky.
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 260; i++) drive(0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0);

    // Asynchronous reset in the middle of the FLUSH cycle.
    drive(0, 0, 0, 32'h1, 0);
    @(posedge clk);
    #2;
    check("async_pre_flush", {31'h0, flush}, 32'h1);
    check("async_pre_pc",    new_pc,         32'h20);
    rst = 1'b1;
    excepttype_i = 32'h0;
    #1;
    check("async_flush",  {31'h0, flush}, 32'h0);
    check("async_busy",   {31'h0, busy},  32'h0);
    check("async_new_pc", new_pc,         32'h0);
    check("async_stall",  {26'h0, stall}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) drive(0, 1, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("queue_drained", q.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
